// File: rtl/mem_access_ctrl.sv
// Purpose : byte-addressed load/store requester for a word-organised data memory (big-endian lanes,
//           sub-word stores via read-modify-write, misaligned accesses aborted without a memory strobe).
// Latency : request accepted at edge T -> done at T+1 (misaligned), T+2 (SW), T+3 (load), T+4 (SB/SH).
// Backpressure: busy is high outside IDLE; requests presented while busy are dropped, not queued.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req, req_write, req_size,        request strobe and attributes (sampled in IDLE only)
//   req_unsigned, req_addr, req_wdata
//   busy, done, misaligned, rdata    status, completion pulse, abort flag, formatted load data
//   mem_dira, mem_write_data,        data memory word address, write word, strobes, read data
//   mem_memwrite, mem_memread, mem_out
module mem_access_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_dira,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Latched request attributes
  logic       wr_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic [1:0] off_q;
  logic       mis_q;

  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] dira_q;
  logic [31:0]       wdat_q;

  // Request decode (IDLE only)
  logic req_is_word;
  logic req_mis;

  // Lane handling on the captured memory word
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_fmt;
  logic [31:0] merged;

  // Size 1x is a full word; 01 is a halfword; 00 is a byte.
  assign req_is_word = req_size[1];
  assign req_mis     = ((req_size == 2'b01) && req_addr[0]) ||
                       (req_is_word && (req_addr[1:0] != 2'b00));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    done         = 1'b0;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (req_mis) begin
            state_nxt = S_DONE;
          end else if (req_write && req_is_word) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        mem_memread = 1'b1;
        state_nxt   = S_CAP;
      end
      S_CAP: begin
        state_nxt = wr_q ? S_WR : S_DONE;
      end
      S_WR: begin
        mem_memwrite = 1'b1;
        state_nxt    = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Flag is only meaningful alongside done, so gate it there.
  assign misaligned = done & mis_q;

  // ---------------------------------------------------------------------------
  // Lane extraction and merge (big-endian: offset 0 is the MSB lane)
  // ---------------------------------------------------------------------------
  always_comb begin
    lane8 = 8'h00;
    case (off_q)
      2'd0:    lane8 = mem_out[31:24];
      2'd1:    lane8 = mem_out[23:16];
      2'd2:    lane8 = mem_out[15:8];
      default: lane8 = mem_out[7:0];
    endcase
    lane16 = off_q[1] ? mem_out[15:0] : mem_out[31:16];

    load_fmt = mem_out;
    if (size_q == 2'b00) begin
      load_fmt = {{24{~uns_q & lane8[7]}}, lane8};
    end else if (size_q == 2'b01) begin
      load_fmt = {{16{~uns_q & lane16[15]}}, lane16};
    end

    // wdat_q still holds the right-justified store data here; it is only
    // overwritten with the merged word on the CAP -> WR edge.
    merged = mem_out;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = wdat_q[7:0];
        2'd1:    merged[23:16] = wdat_q[7:0];
        2'd2:    merged[15:8]  = wdat_q[7:0];
        default: merged[7:0]   = wdat_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdat_q[15:0];
    end else begin
      merged[31:16] = wdat_q[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch, load result, and memory-side registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      dira_q  <= '0;
      wdat_q  <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        wr_q   <= req_write;
        size_q <= req_size;
        uns_q  <= req_unsigned;
        off_q  <= req_addr[1:0];
        mis_q  <= req_mis;
        dira_q <= req_addr[ADDR_W+1:2];
        wdat_q <= req_wdata;
      end
      if (state == S_CAP) begin
        if (wr_q) begin
          wdat_q <= merged;
        end else begin
          rdata_q <= load_fmt;
        end
      end
    end
  end

  assign rdata          = rdata_q;
  assign mem_dira       = dira_q;
  assign mem_write_data = wdat_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int ADDR_W = 15;
  localparam int NW     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              busy, done, misaligned;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_dira;
  logic [31:0]       mem_write_data;
  logic              mem_memwrite, mem_memread;
  logic [31:0]       mem_out = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .misaligned(misaligned), .rdata(rdata),
    .mem_dira(mem_dira), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_out(mem_out)
  );

  // Data memory attached to the DUT
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    if (mem_memread)  mem_out <= mem[mem_dira];
    if (mem_memwrite) mem[mem_dira] <= mem_write_data;
  end

  // Reference state: what memory and rdata should hold by the spec's rules
  logic [31:0] ref_mem [NW];
  logic [31:0] ref_rdata = '0;

  typedef struct {
    logic              mis;
    logic [31:0]       rdata;
    int                due;
    int                nrd;
    int                nwr;
    logic [ADDR_W-1:0] dira;
    logic [31:0]       wdata;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: protocol checks on strobes, scoreboard pop on done
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_memread || mem_memwrite)
        chk("rd_wr_exclusive", {31'b0, mem_memread & mem_memwrite}, 32'd0);
      if (mem_memread) begin
        rd_cnt++;
        if (sb.size() == 0) chk("stray_read", 32'd1, 32'd0);
        else chk("rd_addr", {17'b0, mem_dira}, {17'b0, sb[0].dira});
      end
      if (mem_memwrite) begin
        wr_cnt++;
        if (sb.size() == 0) chk("stray_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", {17'b0, mem_dira}, {17'b0, sb[0].dira});
          chk("wr_data", mem_write_data, sb[0].wdata);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", ncyc, e.due);
          chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
          chk("rdata", rdata, e.rdata);
          chk("read_count", rd_cnt, e.nrd);
          chk("write_count", wr_cnt, e.nwr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic junk_inputs();
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = (ADDR_W+2)'($urandom);
    req_wdata    = $urandom;
  endtask

  // Issue one request from posedge+1 and wait for its completion.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [ADDR_W+1:0] a, input logic [31:0] d, input bit pulse_busy);
    exp_t e;
    int o, lat, sh;
    logic [31:0] old, v, m;
    e.dira = a[ADDR_W+1:2];
    o      = int'(a[1:0]);
    old    = ref_mem[e.dira];
    e.nrd = 0; e.nwr = 0; e.wdata = '0; e.mis = 1'b0;
    if ((sz == 2'b01 && a[0]) || (sz >= 2 && a[1:0] != 2'b00)) begin
      e.mis = 1'b1;
      lat = 1;
    end else if (!wr) begin
      lat = 3; e.nrd = 1;
      if (sz == 2'b00) begin
        v = (old >> (24 - 8*o)) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
        v = (old >> (16 - 8*o)) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = old;
      end
      ref_rdata = v;
    end else if (sz >= 2) begin
      lat = 2; e.nwr = 1;
      e.wdata = d;
      ref_mem[e.dira] = d;
    end else begin
      lat = 4; e.nrd = 1; e.nwr = 1;
      m  = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
      sh = (sz == 2'b00) ? (24 - 8*o) : (16 - 8*o);
      e.wdata = (old & ~(m << sh)) | ((d & m) << sh);
      ref_mem[e.dira] = e.wdata;
    end
    e.rdata = ref_rdata;
    e.due   = ncyc + 1 + lat;
    req = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    junk_inputs();
    if (pulse_busy && lat >= 2) begin
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      junk_inputs();
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    chk({tag, "_done"},  {31'b0, done}, 32'd0);
    chk({tag, "_mis"},   {31'b0, misaligned}, 32'd0);
    chk({tag, "_rd"},    {31'b0, mem_memread}, 32'd0);
    chk({tag, "_wr"},    {31'b0, mem_memwrite}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_dira"},  {17'b0, mem_dira}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int bad_words;
    logic [31:0] v;
    logic [ADDR_W-1:0] w;
    for (int i = 0; i < NW; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 1'b0);          // LW -> 8899AABB
    issue(1'b1, 2'b10, 1'b0, 17'h00010, 32'hFFEE8081, 1'b0);   // SW pattern word
    issue(1'b0, 2'b00, 1'b0, 17'h00013, 32'h0, 1'b0);          // LB  -> FFFFFF81
    issue(1'b0, 2'b00, 1'b1, 17'h00013, 32'h0, 1'b0);          // LBU -> 00000081
    issue(1'b0, 2'b01, 1'b0, 17'h00012, 32'h0, 1'b0);          // LH  -> FFFF8081
    issue(1'b0, 2'b01, 1'b1, 17'h00012, 32'h0, 1'b0);          // LHU -> 00008081
    issue(1'b1, 2'b00, 1'b0, 17'h00021, 32'h0000005A, 1'b0);   // SB -> 115A3344
    issue(1'b1, 2'b10, 1'b0, 17'h00008, 32'hDEADBEEF, 1'b1);   // SW with ignored req pulse
    issue(1'b0, 2'b01, 1'b0, 17'h00001, 32'h0, 1'b0);          // misaligned LH
    issue(1'b1, 2'b10, 1'b0, 17'h00006, 32'h12345678, 1'b0);   // misaligned SW

    // SH interrupted by reset during CAP: memory must stay untouched
    w = 15'd8;
    e.mis = 1'b0; e.rdata = '0; e.due = -1; e.nrd = 1; e.nwr = 0; e.dira = w; e.wdata = 32'hX;
    sb.push_back(e);
    req = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 17'h00022; req_wdata = 32'h0000CAFE;
    @(posedge clk); #1;               // accepted -> RD
    req = 1'b0;
    @(posedge clk); #1;               // CAP
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    ref_rdata = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 2'b10, 1'b0, 17'h00020, 32'h0, 1'b0);          // LW returns untouched word

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [ADDR_W+1:0] a;
      w = ADDR_W'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) w = w | 15'h7FE0;
      a = {w, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom)};
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        junk_inputs();
        @(posedge clk); #1;
      end
    end

    bad_words = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ref_mem[i]) bad_words++;
    chk("final_mem_words_differing", bad_words, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
